// File: rtl/seq_alu_if.sv
// Handshake bundle between operand fetch, the sequential ALU and writeback.
// The issuing/consuming side uses the master modport; the ALU uses slave.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       alu_op;
    logic [WIDTH-1:0] src0;
    logic [WIDTH-1:0] src1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, alu_op, src0, src1, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, busy
    );

    modport slave (
        input  in_valid, alu_op, src0, src1, out_ready,
        output in_ready, out_valid, result, result_hi, zero, busy
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops are registered in one cycle. Multiply and
// divide iterate WIDTH times over operand magnitudes, then the sign is fixed
// up when the HI/LO pair is loaded into the output registers.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_alu_if.slave     bus
);
    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_XOR   = 6'd4;
    localparam logic [5:0] OP_NOR   = 6'd5;
    localparam logic [5:0] OP_SLL   = 6'd6;
    localparam logic [5:0] OP_SRL   = 6'd7;
    localparam logic [5:0] OP_SRA   = 6'd8;
    localparam logic [5:0] OP_SLT   = 6'd9;
    localparam logic [5:0] OP_SLTU  = 6'd10;
    localparam logic [5:0] OP_SGT   = 6'd11;
    localparam logic [5:0] OP_SGTU  = 6'd12;
    localparam logic [5:0] OP_LUI   = 6'd13;
    localparam logic [5:0] OP_MULT  = 6'd16;
    localparam logic [5:0] OP_MULTU = 6'd17;
    localparam logic [5:0] OP_DIV   = 6'd18;
    localparam logic [5:0] OP_DIVU  = 6'd19;

    localparam logic [SHW:0] LAST_CNT = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_e;

    state_e             state_q, state_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;      // product high half / partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;      // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0]   opb_q, opb_d;    // multiplicand or divisor magnitude
    logic               neg_q, neg_d;    // negate product / quotient at the end
    logic               negr_q, negr_d;  // negate remainder at the end
    logic               dz_q, dz_d;      // divisor was zero
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               zero_q, zero_d;

    logic               in_ready_s, accept_s;
    logic [SHW-1:0]     shamt_s;
    logic [WIDTH-1:0]   sc_res_s;
    logic               signed_op_s, is_mul_s, is_div_s;
    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH:0]     mul_sum_s, div_sh_s, div_trial_s;
    logic [2*WIDTH-1:0] prod_s, prod_fin_s;
    logic [WIDTH-1:0]   quo_fin_s, rem_fin_s;

    assign in_ready_s = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign shamt_s    = bus.src0[SHW-1:0];

    // Result of every single-cycle operation for the operands presented now.
    always_comb begin
        sc_res_s = {WIDTH{1'b0}};
        case (bus.alu_op)
            OP_ADD:  sc_res_s = bus.src0 + bus.src1;
            OP_SUB:  sc_res_s = bus.src0 - bus.src1;
            OP_AND:  sc_res_s = bus.src0 & bus.src1;
            OP_OR:   sc_res_s = bus.src0 | bus.src1;
            OP_XOR:  sc_res_s = bus.src0 ^ bus.src1;
            OP_NOR:  sc_res_s = ~(bus.src0 | bus.src1);
            OP_SLL:  sc_res_s = bus.src1 << shamt_s;
            OP_SRL:  sc_res_s = bus.src1 >> shamt_s;
            OP_SRA:  sc_res_s = $unsigned($signed(bus.src1) >>> shamt_s);
            OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.src0) < $signed(bus.src1))};
            OP_SLTU: sc_res_s = {{(WIDTH-1){1'b0}}, (bus.src0 < bus.src1)};
            OP_SGT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.src0) > $signed(bus.src1))};
            OP_SGTU: sc_res_s = {{(WIDTH-1){1'b0}}, (bus.src0 > bus.src1)};
            OP_LUI:  sc_res_s = {bus.src1[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: sc_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Operand classification and magnitudes for the iterative ops.
    always_comb begin
        is_mul_s    = (bus.alu_op == OP_MULT) || (bus.alu_op == OP_MULTU);
        is_div_s    = (bus.alu_op == OP_DIV)  || (bus.alu_op == OP_DIVU);
        signed_op_s = (bus.alu_op == OP_MULT) || (bus.alu_op == OP_DIV);
        a_neg_s     = signed_op_s && bus.src0[WIDTH-1];
        b_neg_s     = signed_op_s && bus.src1[WIDTH-1];
        if (a_neg_s) a_mag_s = {WIDTH{1'b0}} - bus.src0;
        else         a_mag_s = bus.src0;
        if (b_neg_s) b_mag_s = {WIDTH{1'b0}} - bus.src1;
        else         b_mag_s = bus.src1;
    end

    // One shift-add / restoring-divide step, plus the final sign fix-ups.
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        div_sh_s    = {hi_q, lo_q[WIDTH-1]};
        div_trial_s = div_sh_s - {1'b0, opb_q};
        prod_s      = {hi_q, lo_q};
        if (neg_q) prod_fin_s = {(2*WIDTH){1'b0}} - prod_s;
        else       prod_fin_s = prod_s;
        // A zero divisor leaves the dividend magnitude as remainder, so the
        // remainder sign fix-up alone restores src0; only the quotient is forced.
        if (dz_q)       quo_fin_s = {WIDTH{1'b1}};
        else if (neg_q) quo_fin_s = {WIDTH{1'b0}} - lo_q;
        else            quo_fin_s = lo_q;
        if (negr_q) rem_fin_s = {WIDTH{1'b0}} - hi_q;
        else        rem_fin_s = hi_q;
    end

    // Next-state logic: accept, iterate, load the output registers, drain.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opb_d       = opb_q;
        neg_d       = neg_q;
        negr_d      = negr_q;
        dz_d        = dz_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        else                              out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_d = MUL;
                    cnt_d   = {(SHW+1){1'b0}};
                    hi_d    = {WIDTH{1'b0}};
                    lo_d    = b_mag_s;
                    opb_d   = a_mag_s;
                    neg_d   = a_neg_s ^ b_neg_s;
                end else if (accept_s && is_div_s) begin
                    state_d = DIV;
                    cnt_d   = {(SHW+1){1'b0}};
                    hi_d    = {WIDTH{1'b0}};
                    lo_d    = a_mag_s;
                    opb_d   = b_mag_s;
                    neg_d   = a_neg_s ^ b_neg_s;
                    negr_d  = a_neg_s;
                    dz_d    = (bus.src1 == {WIDTH{1'b0}});
                end else if (accept_s) begin
                    result_d    = sc_res_s;
                    result_hi_d = {WIDTH{1'b0}};
                    zero_d      = (sc_res_s == {WIDTH{1'b0}});
                    out_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (cnt_q == LAST_CNT) begin
                    state_d     = IDLE;
                    result_d    = prod_fin_s[WIDTH-1:0];
                    result_hi_d = prod_fin_s[2*WIDTH-1:WIDTH];
                    zero_d      = (prod_fin_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    out_valid_d = 1'b1;
                end else begin
                    {hi_d, lo_d} = {mul_sum_s, lo_q[WIDTH-1:1]};
                    cnt_d        = cnt_q + (SHW+1)'(1);
                end
            end
            DIV: begin
                if (cnt_q == LAST_CNT) begin
                    state_d     = IDLE;
                    result_d    = quo_fin_s;
                    result_hi_d = rem_fin_s;
                    zero_d      = (quo_fin_s == {WIDTH{1'b0}});
                    out_valid_d = 1'b1;
                end else if (!div_trial_s[WIDTH]) begin
                    hi_d  = div_trial_s[WIDTH-1:0];
                    lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                    cnt_d = cnt_q + (SHW+1)'(1);
                end else begin
                    hi_d  = div_sh_s[WIDTH-1:0];
                    lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + (SHW+1)'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {(SHW+1){1'b0}};
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
            opb_q       <= {WIDTH{1'b0}};
            neg_q       <= 1'b0;
            negr_q      <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            result_hi_q <= {WIDTH{1'b0}};
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opb_q       <= opb_d;
            neg_q       <= neg_d;
            negr_q      <= negr_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu at WIDTH=32.
module tb_seq_alu;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle vectors: op, src0, src1, expected result.
    localparam int NSC = 16;
    logic [5:0]  sc_op  [NSC] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                                  6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd20, 6'd14};
    logic [31:0] sc_a   [NSC] = '{32'h7FFFFFFF, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                  32'hAAAA5555, 32'h0, 32'd31, 32'd4,
                                  32'd35, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                                  32'd1, 32'h0, 32'd5, 32'd9};
    logic [31:0] sc_b   [NSC] = '{32'h1, 32'd5, 32'hFF00FF00, 32'h0F0F0000,
                                  32'hFFFF0000, 32'h0, 32'h1, 32'h80000000,
                                  32'h80000000, 32'h1, 32'h1, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'h1234ABCD, 32'd6, 32'd9};
    logic [31:0] sc_exp [NSC] = '{32'h80000000, 32'h0, 32'hF000F000, 32'hFFFFF0F0,
                                  32'h55555555, 32'hFFFFFFFF, 32'h80000000, 32'h08000000,
                                  32'hF0000000, 32'h1, 32'h0, 32'h1,
                                  32'h0, 32'hABCD0000, 32'h0, 32'h0};

    // Multi-cycle vectors: op, src0, src1, expected lo, expected hi.
    localparam int NMC = 9;
    logic [5:0]  mc_op [NMC] = '{6'd16, 6'd17, 6'd16, 6'd19, 6'd18, 6'd18, 6'd18, 6'd19, 6'd18};
    logic [31:0] mc_a  [NMC] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100,
                                 32'hFFFFFFF9, 32'd9, 32'h80000000, 32'd7, 32'd7};
    logic [31:0] mc_b  [NMC] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7,
                                 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE};
    logic [31:0] mc_lo [NMC] = '{32'hFFFFFFF1, 32'h00000001, 32'h1, 32'd14,
                                 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD};
    logic [31:0] mc_hi [NMC] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'd2,
                                 32'hFFFFFFFF, 32'd9, 32'h0, 32'd7, 32'd1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = 6'd0;
        bus.src0      = 32'h0;
        bus.src1      = 32'h0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
        end
        n_cmp++;
        if (bus.result !== 32'h0 || bus.result_hi !== 32'h0 || bus.zero !== 1'b1) begin
            n_err++; $display("FAIL reset_result: got %h %h zero=%b want 0 0 1", bus.result, bus.result_hi, bus.zero);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single();
        for (int i = 0; i < NSC; i++) begin
            bus.alu_op   = sc_op[i];
            bus.src0     = sc_a[i];
            bus.src1     = sc_b[i];
            bus.in_valid = 1'b1;
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready[%0d]: got %b want 1", i, bus.in_ready); end
            tick();
            bus.in_valid = 1'b0;
            bus.src0     = 32'hDEADBEEF;
            bus.src1     = 32'hDEADBEEF;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.result !== sc_exp[i] || bus.result_hi !== 32'h0 ||
                bus.zero !== (sc_exp[i] == 32'h0)) begin
                n_err++;
                $display("FAIL single_op%0d: got v=%b res=%h hi=%h z=%b want v=1 res=%h hi=0 z=%b",
                         sc_op[i], bus.out_valid, bus.result, bus.result_hi, bus.zero,
                         sc_exp[i], (sc_exp[i] == 32'h0));
            end
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain[%0d]: got %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_multicycle();
        logic stall_bad;
        for (int i = 0; i < NMC; i++) begin
            bus.alu_op   = mc_op[i];
            bus.src0     = mc_a[i];
            bus.src1     = mc_b[i];
            bus.in_valid = 1'b1;
            tick();
            bus.alu_op   = 6'd0;
            bus.src0     = 32'h12345678;
            bus.src1     = 32'h9ABCDEF0;
            stall_bad    = (bus.busy !== 1'b1) || (bus.in_ready !== 1'b0) || (bus.out_valid !== 1'b0);
            // in_valid stays high to show nothing more gets in while busy.
            for (int k = 1; k <= W; k++) begin
                tick();
                if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) stall_bad = 1'b1;
            end
            bus.in_valid = 1'b0;
            n_cmp++;
            if (stall_bad !== 1'b0) begin n_err++; $display("FAIL multi_stall_op%0d[%0d]: got bad=%b want 0", mc_op[i], i, stall_bad); end
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_err++; $display("FAIL multi_done_op%0d[%0d]: got v=%b busy=%b rdy=%b want 1 0 1",
                                  mc_op[i], i, bus.out_valid, bus.busy, bus.in_ready);
            end
            n_cmp++;
            if (bus.result !== mc_lo[i] || bus.result_hi !== mc_hi[i] || bus.zero !== (mc_lo[i] == 32'h0)) begin
                n_err++; $display("FAIL multi_result_op%0d[%0d]: got lo=%h hi=%h z=%b want lo=%h hi=%h",
                                  mc_op[i], i, bus.result, bus.result_hi, bus.zero, mc_lo[i], mc_hi[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic frozen_bad;
        bus.out_ready = 1'b0;
        bus.alu_op    = 6'd0;
        bus.src0      = 32'd3;
        bus.src1      = 32'd4;
        bus.in_valid  = 1'b1;
        tick();
        bus.src0 = 32'd1;
        bus.src1 = 32'd1;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'd7) begin
            n_err++; $display("FAIL bp_first: got v=%b res=%h want 1 7", bus.out_valid, bus.result);
        end
        frozen_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 32'd7 ||
                bus.result_hi !== 32'h0 || bus.zero !== 1'b0) frozen_bad = 1'b1;
            tick();
        end
        n_cmp++;
        if (frozen_bad !== 1'b0) begin n_err++; $display("FAIL bp_frozen: got bad=%b want 0", frozen_bad); end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_on_drain: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'd2) begin
            n_err++; $display("FAIL bp_next: got v=%b res=%h want 1 2", bus.out_valid, bus.result);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int good;
        good          = 0;
        bus.out_ready = 1'b1;
        bus.alu_op    = 6'd0;
        for (int i = 0; i < 10; i++) begin
            bus.src0     = 32'(i);
            bus.src1     = 32'(16 * i + 1);
            bus.in_valid = 1'b1;
            tick();
            if (bus.out_valid === 1'b1 && bus.result === 32'(17 * i + 1)) good++;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (good !== 10) begin n_err++; $display("FAIL b2b_count: got %0d good want 10", good); end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        logic ghost;
        bus.out_ready = 1'b1;
        bus.alu_op    = 6'd16;
        bus.src0      = 32'd7;
        bus.src1      = 32'd9;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_low: got %b want 0", bus.in_ready); end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL mid_abort: got v=%b busy=%b want 0 0", bus.out_valid, bus.busy);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_high: got %b want 1", bus.in_ready); end
        ghost = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) ghost = 1'b1;
        end
        n_cmp++;
        if (ghost !== 1'b0) begin n_err++; $display("FAIL mid_no_ghost: got %b want 0", ghost); end
        bus.alu_op   = 6'd0;
        bus.src0     = 32'd2;
        bus.src1     = 32'd3;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'd5) begin
            n_err++; $display("FAIL mid_add_after: got v=%b res=%h want 1 5", bus.out_valid, bus.result);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_multicycle();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
